// File: rtl/pong_pkg.sv
// Shared constants for the pong input path: quadrature phase states, paddle defaults
// and the decoder sub-counter format.
package pong_pkg;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_t;

    localparam int unsigned POS_W_DEF   = 4;
    localparam int unsigned POS_MAX_DEF = 12;

    localparam int unsigned SUB_W = 3;
    localparam logic signed [SUB_W-1:0] SUB_MAX = 3'sb011;
    localparam logic signed [SUB_W-1:0] SUB_MIN = 3'sb101;

    // Successor of a phase state under clockwise rotation.
    function automatic quad_t cw_next(input quad_t s);
        case (s)
            Q00:     return Q01;
            Q01:     return Q11;
            Q11:     return Q10;
            default: return Q00;
        endcase
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One rotary encoder: 2-flop synchroniser, optional debounce (DEBOUNCE_EN) and
// quadrature decoder. up/dn/glitch are next-cycle pulse values; the top registers them.
module quad_channel
    import pong_pkg::*;
#(
    parameter int unsigned DB_W = 12
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic a_i,
    input  logic b_i,
    output logic up_o,
    output logic dn_o,
    output logic glitch_o
);

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] deb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {a_i, b_i};
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    logic [1:0]      deb_q, deb_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];

    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == '1) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_q    <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            deb_q    <= deb_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    assign deb = deb_q;
`else
    // DB_W has no effect without the debounce stage.
    if (DB_W == 0) begin : g_db_ignored
    end

    assign deb = sync2_q;
`endif

    quad_t                   cur;
    quad_t                   prev_q, prev_d;
    logic signed [SUB_W-1:0] sub_q, sub_d;

    always_comb begin
        cur      = quad_t'(deb);
        prev_d   = cur;
        sub_d    = sub_q;
        up_o     = 1'b0;
        dn_o     = 1'b0;
        glitch_o = 1'b0;
        if (cur != prev_q) begin
            if (cur == cw_next(prev_q)) begin
                if (sub_q == SUB_MAX) begin
                    up_o  = 1'b1;
                    sub_d = '0;
                end else begin
                    sub_d = sub_q + 3'sd1;
                end
            end else if (prev_q == cw_next(cur)) begin
                if (sub_q == SUB_MIN) begin
                    dn_o  = 1'b1;
                    sub_d = '0;
                end else begin
                    sub_d = sub_q - 3'sd1;
                end
            end else begin
                // Both phases moved at once: direction unknown, drop the partial count.
                glitch_o = 1'b1;
                sub_d    = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= Q00;
            sub_q  <= '0;
        end else begin
            prev_q <= prev_d;
            sub_q  <= sub_d;
        end
    end

endmodule

// File: rtl/paddle_input.sv
// Pad-ring input conditioning for pong: start button and two quadrature paddles.
// Debounce is enabled by defining DEBOUNCE_EN.
module paddle_input
    import pong_pkg::*;
#(
    parameter int unsigned DB_W    = 12,
    parameter int unsigned POS_W   = POS_W_DEF,
    parameter int unsigned POS_MAX = POS_MAX_DEF
) (
    input  logic             clk12mhz,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             p1_a_i,
    input  logic             p1_b_i,
    input  logic             p2_a_i,
    input  logic             p2_b_i,
    output logic             start_o,
    output logic             p1_up_o,
    output logic             p1_dn_o,
    output logic             p2_up_o,
    output logic             p2_dn_o,
    output logic [POS_W-1:0] p1_pos_o,
    output logic [POS_W-1:0] p2_pos_o,
    output logic             glitch_o
);

    localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_RST = POS_W'(POS_MAX / 2);

    logic p1_up, p1_dn, p1_gl;
    logic p2_up, p2_dn, p2_gl;

    quad_channel #(.DB_W(DB_W)) u_p1 (
        .clk_i    (clk12mhz),
        .rst_ni   (reset_n),
        .a_i      (p1_a_i),
        .b_i      (p1_b_i),
        .up_o     (p1_up),
        .dn_o     (p1_dn),
        .glitch_o (p1_gl)
    );

    quad_channel #(.DB_W(DB_W)) u_p2 (
        .clk_i    (clk12mhz),
        .rst_ni   (reset_n),
        .a_i      (p2_a_i),
        .b_i      (p2_b_i),
        .up_o     (p2_up),
        .dn_o     (p2_dn),
        .glitch_o (p2_gl)
    );

    logic [1:0] st_sync_q;
    logic       st_deb;

    always_ff @(posedge clk12mhz or negedge reset_n) begin
        if (!reset_n) begin
            st_sync_q <= '0;
        end else begin
            st_sync_q <= {st_sync_q[0], start_i};
        end
    end

`ifdef DEBOUNCE_EN
    logic            st_deb_q, st_deb_d;
    logic [DB_W-1:0] st_cnt_q, st_cnt_d;

    always_comb begin
        st_deb_d = st_deb_q;
        st_cnt_d = '0;
        if (st_sync_q[1] != st_deb_q) begin
            if (st_cnt_q == '1) begin
                st_deb_d = st_sync_q[1];
            end else begin
                st_cnt_d = st_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk12mhz or negedge reset_n) begin
        if (!reset_n) begin
            st_deb_q <= 1'b0;
            st_cnt_q <= '0;
        end else begin
            st_deb_q <= st_deb_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign st_deb = st_deb_q;
`else
    assign st_deb = st_sync_q[1];
`endif

    logic             st_prev_q;
    logic             start_q;
    logic             p1_up_q, p1_dn_q, p2_up_q, p2_dn_q, glitch_q;
    logic [POS_W-1:0] p1_pos_q, p1_pos_d;
    logic [POS_W-1:0] p2_pos_q, p2_pos_d;

    // Positions follow the unregistered step so they change on the same edge as the pulse.
    always_comb begin
        p1_pos_d = p1_pos_q;
        if (p1_up && p1_pos_q != POS_TOP) begin
            p1_pos_d = p1_pos_q + 1'b1;
        end else if (p1_dn && p1_pos_q != '0) begin
            p1_pos_d = p1_pos_q - 1'b1;
        end
        p2_pos_d = p2_pos_q;
        if (p2_up && p2_pos_q != POS_TOP) begin
            p2_pos_d = p2_pos_q + 1'b1;
        end else if (p2_dn && p2_pos_q != '0) begin
            p2_pos_d = p2_pos_q - 1'b1;
        end
    end

    always_ff @(posedge clk12mhz or negedge reset_n) begin
        if (!reset_n) begin
            st_prev_q <= 1'b0;
            start_q   <= 1'b0;
            p1_up_q   <= 1'b0;
            p1_dn_q   <= 1'b0;
            p2_up_q   <= 1'b0;
            p2_dn_q   <= 1'b0;
            glitch_q  <= 1'b0;
            p1_pos_q  <= POS_RST;
            p2_pos_q  <= POS_RST;
        end else begin
            st_prev_q <= st_deb;
            start_q   <= st_deb & ~st_prev_q;
            p1_up_q   <= p1_up;
            p1_dn_q   <= p1_dn;
            p2_up_q   <= p2_up;
            p2_dn_q   <= p2_dn;
            glitch_q  <= p1_gl | p2_gl;
            p1_pos_q  <= p1_pos_d;
            p2_pos_q  <= p2_pos_d;
        end
    end

    assign start_o  = start_q;
    assign p1_up_o  = p1_up_q;
    assign p1_dn_o  = p1_dn_q;
    assign p2_up_o  = p2_up_q;
    assign p2_dn_o  = p2_dn_q;
    assign glitch_o = glitch_q;
    assign p1_pos_o = p1_pos_q;
    assign p2_pos_o = p2_pos_q;

endmodule

// File: doc/paddle_input.md
# paddle_input

Input-conditioning stage between the pad ring and the pong core. Synchronises and debounces the start button and two rotary quadrature encoders, one per player, then decodes the encoder phases. It turns detent rotations into up/down step pulses and saturating paddle positions for the game logic, and emits a single-cycle start pulse.

## Interface
Parameters:
- DB_W, 12: debounce counter width; a change is accepted after 2**DB_W consecutive mismatched cycles.
- POS_W, 4: paddle position width.
- POS_MAX, 12: highest legal paddle position (16-row matrix, paddle length 4).

Ports:
- clk12mhz  in  1  system clock; single clock domain.
- reset_n  in  1  reset; asynchronous assert, active-low.
- start_i  in  1  raw start button, active-high, asynchronous.
- p1_a_i, p1_b_i  in  1 each  raw player-1 encoder phases.
- p2_a_i, p2_b_i  in  1 each  raw player-2 encoder phases.
- start_o  out  1  one-cycle pulse on debounced start rising edge.
- p1_up_o, p1_dn_o  out  1 each  one-cycle player-1 detent step pulses.
- p2_up_o, p2_dn_o  out  1 each  one-cycle player-2 detent step pulses.
- p1_pos_o, p2_pos_o  out  POS_W each  registered paddle positions.
- glitch_o  out  1  one-cycle pulse on any illegal quadrature transition, either player.

## Operation
Synchronisation:
- Every raw input passes through a 2-flop synchroniser.
- The synchroniser flops reset to 0.

Debounce, per input:
- Each input has a debounced register and a DB_W-bit counter, both reset to 0.
- If the synced value equals the debounced value, the counter is cleared to 0.
- Otherwise the counter increments.
- When the counter equals 2**DB_W-1 and the synced value still mismatches, the debounced register takes the synced value and the counter clears.

Quadrature decode, per encoder, on the debounced {A,B}:
- Previous {A,B} is held in a register, reset to 00.
- Clockwise sequence is 00→01→11→10→00; counter-clockwise is the reverse.
- Each encoder has a signed 3-bit sub-counter, reset to 0.
- Valid CW transition: if sub == +3, assert up and clear sub; else sub + 1.
- Valid CCW transition: if sub == −3, assert dn and clear sub; else sub − 1.
- Both bits changing in one cycle is illegal: sub clears, no step, glitch_o asserts.
- No change: nothing happens.
- Result: exactly one step per four valid quarter-transitions in one direction.

Position:
- up increments the position, saturating at POS_MAX.
- dn decrements the position, saturating at 0.
- up and dn are mutually exclusive by construction.

Start:
- start_o is (debounced & ~debounced_prev), registered.

Reset:
- start_o, all up/dn pulses and glitch_o reset to 0.
- p1_pos_o and p2_pos_o reset to POS_MAX/2, floored (6 by default).
- reset_n low mid-operation clears everything asynchronously, including partial sub-counts and debounce counts.
- If pins idle at 11 after reset, the first accepted 00→11 change is illegal: one glitch_o pulse, no step.

## Timing
- Raw edge sampled at clock k reaches the synchroniser output at k+2.
- With DEBOUNCE_EN, the debounced value updates at k+2+2**DB_W.
- Step, glitch and start pulses are registered one cycle after the debounced/synced value changes.
- The position updates on that same edge, coincident with its step pulse.
- All pulses are exactly one cycle wide.
- Players are fully independent; simultaneous events on both encoders are all processed in the same cycle.

## Configuration
- DEBOUNCE_EN defined: debounce stage as described.
- DEBOUNCE_EN undefined: debounce counters are removed; the debounced value equals the synchroniser output, giving a 3-cycle pin-to-pulse latency.
- The DB_W parameter is ignored when DEBOUNCE_EN is undefined.

## Structure
- pong_pkg holds the quadrature state constants (Q00, Q01, Q11, Q10), default POS_W/POS_MAX and the sub-counter width.
- Sub-module quad_channel: synchroniser, debounce and decoder for one encoder, outputting up/dn/glitch.
- quad_channel is instantiated twice; position registers and start logic live in the top.

## Test plan
Use DB_W=2 with DEBOUNCE_EN defined unless stated.
- Reset released, inputs all 0 → both positions 6; every pulse output 0 for 100 cycles.
- Player 1 driven through 4 CW quarter-steps, each held 10 cycles → exactly one p1_up_o pulse; p1_pos_o 6→7; player-2 outputs unchanged.
- Player 2 driven through 32 CCW quarter-steps → 8 p2_dn_o pulses; p2_pos_o saturates at 0 after 6 steps; no glitch_o.
- p1_a_i toggled for 2 cycles only, then restored → no debounced change, no pulse, p1_pos_o unchanged.
- p1_{a,b} jump 00→11 and are held → one glitch_o pulse; sub-counter cleared, so the next 4 CW steps from 11 produce exactly one up.
- start_i held high 20 cycles → single start_o pulse 1 cycle after the debounced rise.
- With DEBOUNCE_EN undefined → same pulse 3 cycles after the pin edge.
- reset_n asserted after 3 CW quarter-steps, then 1 more CW step after release → no up pulse; position back to 6.
